// File: rtl/crc_check_pkg.sv
// Shared CRC definitions: default polynomial/seed and FSM state encodings.
// Both the CRC generator and the checker take their defaults from here.
package crc_check_pkg;

  localparam int         CRC_WIDTH_DEF = 8;
  localparam logic [7:0] CRC_SEED_DEF  = 8'hD8;
  localparam logic [7:0] CRC_TAPS_DEF  = 8'b0100_0100;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_CHECK = 2'd3;

endpackage

// File: rtl/crc_lfsr_step.sv
// One-bit LFSR advance for the serial CRC. This is the single definition of
// the generator rule, shared by the generator and the checker.
module crc_lfsr_step #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TAPS = 8'b0100_0100
) (
  input  logic [W-1:0] lfsr_i,
  input  logic         bit_i,
  output logic [W-1:0] next_o
);

  logic fb;

  assign fb = bit_i ^ lfsr_i[0];

  // Shift right, feedback into the top stage and into every tapped stage.
  always_comb begin
    next_o        = '0;
    next_o[W-1]   = fb;
    for (int i = 0; i < W - 1; i++) begin
      next_o[i] = lfsr_i[i+1] ^ (TAPS[i] & fb);
    end
  end

endmodule

// File: rtl/crc_check.sv
// Serial CRC checker. Payload bits run through the LFSR while ACTIVE is high;
// the received CRC bits (LSB first) are then compared against the LFSR,
// which is drained one bit per CRC bit. A verdict is pulsed on DONE and
// held on CRC_OK / CRC_ERR until the next frame starts.
module crc_check
  import crc_check_pkg::*;
#(
  parameter int                    LFSR_WIDTH = CRC_WIDTH_DEF,
  parameter logic [LFSR_WIDTH-1:0] SEED       = CRC_SEED_DEF,
  parameter logic [LFSR_WIDTH-1:0] TAPS       = CRC_TAPS_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA,
  input  logic ACTIVE,
  input  logic CRC_VLD,
  output logic BUSY,
  output logic DONE,
  output logic CRC_OK,
  output logic CRC_ERR
);

  localparam int              CW   = (LFSR_WIDTH > 1) ? $clog2(LFSR_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(LFSR_WIDTH - 1);

  logic [1:0]            state_q, state_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [LFSR_WIDTH-1:0] lfsr_run, lfsr_seed;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  mis_q, mis_d;
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;

  logic do_start, do_abort, do_crc, do_pay, to_gap;
  logic mis_all;

  // Advance of the running LFSR, and of the seed for the first payload bit.
  crc_lfsr_step #(.W(LFSR_WIDTH), .TAPS(TAPS)) u_step_run (
    .lfsr_i (lfsr_q),
    .bit_i  (DATA),
    .next_o (lfsr_run)
  );

  crc_lfsr_step #(.W(LFSR_WIDTH), .TAPS(TAPS)) u_step_seed (
    .lfsr_i (SEED),
    .bit_i  (DATA),
    .next_o (lfsr_seed)
  );

  // Sticky mismatch including the CRC bit currently on the line.
  assign mis_all = mis_q | (DATA ^ lfsr_q[0]);

  // Decode what this cycle does; ACTIVE always wins over CRC_VLD.
  always_comb begin
    do_start = 1'b0;
    do_abort = 1'b0;
    do_crc   = 1'b0;
    do_pay   = 1'b0;
    to_gap   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        do_start = ACTIVE;
      end
      ST_DATA: begin
        if (ACTIVE)       do_pay = 1'b1;
        else if (CRC_VLD) do_crc = 1'b1;
        else              to_gap = 1'b1;
      end
      ST_GAP: begin
        if (ACTIVE) begin
          do_abort = 1'b1;
          do_start = 1'b1;
        end else if (CRC_VLD) begin
          do_crc = 1'b1;
        end
      end
      ST_CHECK: begin
        if (ACTIVE) begin
          do_abort = 1'b1;
          do_start = 1'b1;
        end else if (CRC_VLD) begin
          do_crc = 1'b1;
        end else begin
          do_abort = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Next-state values; a restart after an abort keeps the abort verdict
  // visible for the DONE cycle and the DATA state clears it afterwards.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    done_d  = 1'b0;
    ok_d    = ok_q;
    err_d   = err_q;

    if (state_q == ST_DATA) begin
      ok_d  = 1'b0;
      err_d = 1'b0;
    end

    if (do_pay) lfsr_d = lfsr_run;

    if (to_gap) state_d = ST_GAP;

    if (do_crc) begin
      lfsr_d = lfsr_q >> 1;
      mis_d  = mis_all;
      cnt_d  = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        done_d  = 1'b1;
        ok_d    = ~mis_all;
        err_d   = mis_all;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end else begin
        state_d = ST_CHECK;
      end
    end

    if (do_abort) begin
      done_d  = 1'b1;
      ok_d    = 1'b0;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end

    if (do_start) begin
      state_d = ST_DATA;
      lfsr_d  = lfsr_seed;
      cnt_d   = '0;
      mis_d   = 1'b0;
      if (!do_abort) begin
        ok_d  = 1'b0;
        err_d = 1'b0;
      end
    end

    if (state_q != ST_IDLE && state_q != ST_DATA &&
        state_q != ST_GAP && state_q != ST_CHECK) begin
      state_d = ST_IDLE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      done_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      done_q  <= done_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign CRC_OK  = ok_q;
  assign CRC_ERR = err_q;

endmodule

// File: tb/tb_crc_check.sv
// Directed bench for crc_check: a table of whole frames with hand-computed
// CRCs, followed by hand-written sequences for back-to-back frames,
// abort-and-restart, CRC_VLD while idle and reset in the middle of a frame.
module tb_crc_check;

  logic CLK, RST, DATA, ACTIVE, CRC_VLD;
  logic BUSY, DONE, CRC_OK, CRC_ERR;

  crc_check dut (
    .CLK     (CLK),
    .RST     (RST),
    .DATA    (DATA),
    .ACTIVE  (ACTIVE),
    .CRC_VLD (CRC_VLD),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .CRC_OK  (CRC_OK),
    .CRC_ERR (CRC_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] pay;
    int         plen;
    int         gap;
    logic [7:0] crc;
    int         ncrc;
    bit         vpay;
    bit         ok;
    bit         err;
  } vec_t;

  typedef struct {
    int   cyc;
    logic ok;
    logic err;
  } ev_t;

  vec_t vt[9];
  ev_t  done_ev[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  logic smp_busy, smp_ok, smp_err, smp_done;
  bit   both_seen;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  // One clock: sample outputs at the falling edge, then drive new inputs.
  task automatic step(input logic a, input logic v, input logic d);
    @(negedge CLK);
    cyc++;
    smp_busy = BUSY;
    smp_ok   = CRC_OK;
    smp_err  = CRC_ERR;
    smp_done = DONE;
    if (DONE === 1'b1) done_ev.push_back('{cyc, CRC_OK, CRC_ERR});
    if (CRC_OK === 1'b1 && CRC_ERR === 1'b1) both_seen = 1'b1;
    ACTIVE  = a;
    CRC_VLD = v;
    DATA    = d;
  endtask

  task automatic send_frame(input logic [7:0] pay, input int plen, input int gap,
                            input logic [7:0] crc, input int ncrc, input bit vpay,
                            input string tag);
    for (int i = 0; i < plen; i++) step(1'b1, vpay, pay[i]);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < ncrc; i++) step(1'b0, 1'b1, crc[i]);
    chk({tag, "_busy_in_frame"}, int'(smp_busy), 1);
    last_cyc = cyc;
    if (ncrc < 8) step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_cyc;
    int r;
    logic [7:0] crc14;

    vt[0] = '{8'h00, 8, 0, 8'h14, 8, 1'b0, 1'b1, 1'b0};
    vt[1] = '{8'h00, 8, 0, 8'h15, 8, 1'b0, 1'b0, 1'b1};
    vt[2] = '{8'h00, 8, 3, 8'h14, 8, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h00, 8, 0, 8'h14, 5, 1'b0, 1'b0, 1'b1};
    vt[4] = '{8'hFF, 8, 0, 8'h72, 8, 1'b0, 1'b1, 1'b0};
    vt[5] = '{8'hA5, 8, 1, 8'h7D, 8, 1'b1, 1'b1, 1'b0};
    vt[6] = '{8'h01, 1, 0, 8'hA8, 8, 1'b0, 1'b1, 1'b0};
    vt[7] = '{8'hA5, 8, 0, 8'h7C, 8, 1'b0, 1'b0, 1'b1};
    vt[8] = '{8'hFF, 8, 0, 8'hF2, 8, 1'b0, 1'b0, 1'b1};
    crc14 = 8'h14;

    ACTIVE = 1'b0; CRC_VLD = 1'b0; DATA = 1'b0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_ok",   int'(CRC_OK), 0);
    chk("rst_err",  int'(CRC_ERR), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("rst_idle_busy", int'(smp_busy), 0);

    // Table of whole frames.
    for (int i = 0; i < 9; i++) begin
      done_ev.delete();
      both_seen = 1'b0;
      send_frame(vt[i].pay, vt[i].plen, vt[i].gap, vt[i].crc, vt[i].ncrc,
                 vt[i].vpay, $sformatf("v%0d", i));
      exp_cyc = last_cyc + ((vt[i].ncrc == 8) ? 1 : 2);
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_done_count", i), done_ev.size(), 1);
      if (done_ev.size() > 0) begin
        chk($sformatf("v%0d_done_cycle", i), done_ev[0].cyc, exp_cyc);
        chk($sformatf("v%0d_ok", i),  int'(done_ev[0].ok),  int'(vt[i].ok));
        chk($sformatf("v%0d_err", i), int'(done_ev[0].err), int'(vt[i].err));
      end
      chk($sformatf("v%0d_ok_held", i),  int'(smp_ok),  int'(vt[i].ok));
      chk($sformatf("v%0d_err_held", i), int'(smp_err), int'(vt[i].err));
      chk($sformatf("v%0d_busy_after", i), int'(smp_busy), 0);
      chk($sformatf("v%0d_exclusive", i), int'(both_seen), 0);
    end

    // CRC_VLD in IDLE is ignored; the previous ERR verdict stays.
    done_ev.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, i[0]);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("idle_vld_done_count", done_ev.size(), 0);
    chk("idle_vld_err_held", int'(smp_err), 1);
    chk("idle_vld_ok", int'(smp_ok), 0);
    chk("idle_vld_busy", int'(smp_busy), 0);

    // Back-to-back frames: OK then ERR, no idle cycle between them.
    done_ev.delete();
    send_frame(8'h00, 8, 0, 8'h14, 8, 1'b0, "b2b_a");
    r = last_cyc;
    send_frame(8'h00, 8, 0, 8'h15, 8, 1'b0, "b2b_b");
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_done_count", done_ev.size(), 2);
    if (done_ev.size() == 2) begin
      chk("b2b_first_cycle", done_ev[0].cyc, r + 1);
      chk("b2b_first_ok",    int'(done_ev[0].ok), 1);
      chk("b2b_first_err",   int'(done_ev[0].err), 0);
      chk("b2b_second_cycle", done_ev[1].cyc, last_cyc + 1);
      chk("b2b_second_ok",    int'(done_ev[1].ok), 0);
      chk("b2b_second_err",   int'(done_ev[1].err), 1);
    end

    // ACTIVE during GAP: abort verdict for one cycle, then a fresh frame.
    done_ev.delete();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    r = cyc;
    step(1'b1, 1'b0, 1'b0);
    chk("restart_done",  int'(smp_done), 1);
    chk("restart_err",   int'(smp_err), 1);
    chk("restart_ok",    int'(smp_ok), 0);
    chk("restart_busy",  int'(smp_busy), 1);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_clear_done", int'(smp_done), 0);
    chk("restart_clear_err",  int'(smp_err), 0);
    chk("restart_clear_ok",   int'(smp_ok), 0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, crc14[i]);
    last_cyc = cyc;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("restart_done_count", done_ev.size(), 2);
    if (done_ev.size() == 2) begin
      chk("restart_abort_cycle", done_ev[0].cyc, r + 1);
      chk("restart_final_cycle", done_ev[1].cyc, last_cyc + 1);
      chk("restart_final_ok",    int'(done_ev[1].ok), 1);
    end

    // Reset after 4 payload bits: frame discarded, next frame starts clean.
    done_ev.delete();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    #2;
    chk("midrst_busy_before", int'(BUSY), 1);
    RST = 1'b0;
    #1;
    chk("midrst_busy_async", int'(BUSY), 0);
    chk("midrst_ok_async",   int'(CRC_OK), 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_no_done", done_ev.size(), 0);
    send_frame(8'h00, 8, 0, 8'h14, 8, 1'b0, "midrst");
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("midrst_done_count", done_ev.size(), 1);
    if (done_ev.size() == 1) begin
      chk("midrst_cycle", done_ev[0].cyc, last_cyc + 1);
      chk("midrst_ok",    int'(done_ev[0].ok), 1);
      chk("midrst_err",   int'(done_ev[0].err), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_check.md
CRC_CHECK -- requirements
Module: crc_check

Interface
REQ-001 Parameter LFSR_WIDTH, default 8, CRC register width in bits.
REQ-002 Parameter SEED, default 8'hD8, LFSR value loaded at frame start.
REQ-003 Parameter TAPS, default 8'b0100_0100, bit i set means LFSR stage i receives feedback XOR.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset; asynchronous, active-low.
REQ-006 DATA  input  1  serial line; payload bits LSB first, then CRC bits LSB first.
REQ-007 ACTIVE  input  1  high while DATA carries payload bits.
REQ-008 CRC_VLD  input  1  high while DATA carries received CRC bits.
REQ-009 BUSY  output  1  high from frame start until the verdict is issued.
REQ-010 DONE  output  1  one-cycle pulse when a verdict is issued.
REQ-011 CRC_OK  output  1  verdict: received CRC matched; held until the next frame start.
REQ-012 CRC_ERR  output  1  verdict: mismatch or aborted frame; held until the next frame start.

Function
REQ-013 The block SHALL sample DATA, ACTIVE and CRC_VLD on every rising CLK edge.
REQ-014 The FSM SHALL have exactly four states: IDLE, DATA, GAP and CHECK.
REQ-015 In IDLE with ACTIVE=1, the block SHALL load LFSR=SEED, apply the update to that bit, enter DATA and set BUSY.
- Entering DATA from IDLE SHALL clear CRC_OK and CRC_ERR.
REQ-016 The LFSR update SHALL be the generator rule for each payload bit.
- fb = DATA ^ LFSR[0]
- next[W-1] = fb
- next[i] = LFSR[i+1] ^ (TAPS[i] & fb), for i < W-1
REQ-017 In DATA, behaviour by inputs:
- ACTIVE=1: update the LFSR.
- ACTIVE=0, CRC_VLD=0: enter GAP, LFSR held.
- ACTIVE=0, CRC_VLD=1: enter CHECK and process that bit as CRC bit 0.
REQ-018 In GAP, the LFSR SHALL hold; CRC_VLD=1 SHALL enter CHECK and process that bit as CRC bit 0.
REQ-019 In CHECK, each cycle with CRC_VLD=1 SHALL do the following:
- Compare DATA against LFSR[0] and latch any mismatch in a sticky flag.
- Shift the LFSR right with zero fill.
- Increment a bit counter of width clog2(LFSR_WIDTH).
REQ-020 On the cycle after the LFSR_WIDTH-th CRC bit is sampled, the block SHALL do all of the following:
- Pulse DONE.
- Drive CRC_OK = !mismatch and CRC_ERR = mismatch.
- Clear BUSY and return to IDLE.
REQ-021 CRC_VLD=0 in CHECK before LFSR_WIDTH bits SHALL abort: DONE pulse, CRC_ERR=1, CRC_OK=0, return to IDLE.
REQ-022 ACTIVE=1 while in GAP or CHECK SHALL abort as in REQ-021 and, in the same cycle, start a new frame as in REQ-015.
- In this case CRC_OK and CRC_ERR SHALL show the abort verdict in the DONE cycle and clear on the following cycle.
REQ-023 ACTIVE and CRC_VLD both high in DATA SHALL be treated as a payload bit; CRC_VLD is ignored.
REQ-024 CRC_VLD=1 in IDLE SHALL be ignored, with no DONE and no verdict change.
REQ-025 A new frame MAY start in the cycle immediately after DONE; back-to-back frames SHALL need no idle gap.
REQ-026 CRC_OK and CRC_ERR SHALL never be high simultaneously.

Reset
REQ-027 RST low SHALL immediately force all of the following, regardless of CLK:
- FSM=IDLE, LFSR=SEED, counter=0, mismatch=0.
- BUSY=0, DONE=0, CRC_OK=0, CRC_ERR=0.
REQ-028 Reset mid-frame SHALL discard the frame with no DONE pulse; the first ACTIVE=1 edge after RST rises SHALL start a fresh frame.

Structure
REQ-029 LFSR_WIDTH, SEED, TAPS defaults and the FSM state encodings SHALL live in a shared CRC definitions header, included by both the generator and this checker.
REQ-030 The LFSR next-state logic (REQ-016) SHALL be a sub-module crc_lfsr_step (combinational: lfsr, bit -> next), so generator and checker cannot diverge.

Verification
REQ-031 Reset, payload 0x00 (8 bits), then CRC 0x14 (bits 0,0,1,0,1,0,0,0) -> DONE pulse one cycle after the last CRC bit, CRC_OK=1, CRC_ERR=0.
REQ-032 Payload 0x00, then CRC 0x15 -> DONE, CRC_ERR=1, CRC_OK=0.
REQ-033 Payload 0x00, 3-cycle gap with both inputs low, then CRC 0x14 -> CRC_OK=1; latency and result are unchanged by the gap.
REQ-034 Payload 0x00, 5 CRC bits, then CRC_VLD low -> DONE next cycle with CRC_ERR=1.
REQ-035 Two frames back-to-back with no gap: first with CRC 0x14, second with CRC 0x15 -> two DONE pulses; OK first, ERR second.
REQ-036 RST low after 4 payload bits, then a full valid frame -> no DONE for the aborted frame; valid frame gives CRC_OK=1.
